coin_dispenser: RTL and testbench

- Change-output side of the vending datapath; sits after the refund decision.
- Takes a refund amount and ejects physical coins one at a time from five denomination hoppers, largest denomination first.
- Drives each coin with the same one-hot denomination code the coin-acceptor path uses: 5'b00001=5, 00010=10, 00100=20, 01000=50, 10000=100.
- Handshakes every coin with the hopper mechanism, tracks hopper inventory, and reports per-denomination counts, shortfall and jam faults.

---
 rtl/coin_dispenser.sv | 179 +++++++++++++++++
 tb/tb_coin_dispenser.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_dispenser.sv
// Change dispenser: pays a refund amount out of five denomination hoppers,
// largest coin first, one handshaked coin at a time, with inventory and jam tracking.
module coin_dispenser #(
  parameter logic [3:0] HOPPER_INIT  = 4'd15,
  parameter int         PULSE_CYCLES = 4,
  parameter logic [7:0] ACK_TIMEOUT  = 8'd255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] amount,
  input  logic       load_hopper,
  input  logic [4:0] load_denom,
  input  logic [3:0] load_count,
  input  logic       coin_ack,
  output logic [4:0] coin,
  output logic       coin_out,
  output logic       busy,
  output logic       done,
  output logic       short,
  output logic       fault,
  output logic [7:0] remaining,
  output logic [3:0] five,
  output logic [3:0] ten,
  output logic [3:0] twenty,
  output logic [3:0] fifty,
  output logic [3:0] hundred
);

  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, SELECT, DRIVE, WAIT_ACK, DONE, FAULT} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  remaining_reg;
  logic [4:0]  coin_reg;
  logic        short_reg;
  logic [PW-1:0] pulse_cnt_reg;
  logic [7:0]  wait_cnt_reg;

  logic [4:0]  eligible;
  logic [4:0]  pick;
  logic [7:0]  coin_val;
  logic [4:0][3:0] count_all;
  logic        start_take;
  logic        load_take;
  logic        ack_take;
  logic        pulse_last;
  logic        timeout;

  // Hopper index 0..4 maps to 5, 10, 20, 50, 100, matching the one-hot bit position.
  function automatic logic [7:0] denom_val(input int idx);
    case (idx)
      0:       return 8'd5;
      1:       return 8'd10;
      2:       return 8'd20;
      3:       return 8'd50;
      4:       return 8'd100;
      default: return 8'd0;
    endcase
  endfunction

  assign start_take = (state_reg == IDLE) && start;
  assign load_take  = (state_reg == IDLE) && load_hopper && !start;
  assign ack_take   = (state_reg == WAIT_ACK) && coin_ack;
  assign pulse_last = (pulse_cnt_reg == PW'(PULSE_CYCLES - 1));
  assign timeout    = (state_reg == WAIT_ACK) && !coin_ack &&
                      (wait_cnt_reg == ACK_TIMEOUT - 8'd1);

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_hopper
      logic [3:0] hop_reg;
      logic [3:0] cnt_reg;

      // Non-one-hot selects never equal a single bit, so they load nothing.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          hop_reg <= HOPPER_INIT;
        end else if (load_take && (load_denom == (5'b00001 << gi))) begin
          hop_reg <= load_count;
        end else if (ack_take && coin_reg[gi]) begin
          hop_reg <= hop_reg - 4'd1;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg <= 4'd0;
        end else if (start_take) begin
          cnt_reg <= 4'd0;
        end else if (ack_take && coin_reg[gi] && (cnt_reg != 4'hF)) begin
          cnt_reg <= cnt_reg + 4'd1;
        end
      end

      assign eligible[gi]  = (remaining_reg >= denom_val(gi)) && (hop_reg != 4'd0);
      assign count_all[gi] = cnt_reg;
    end
  endgenerate

  // Later (larger) indices overwrite earlier ones, so the largest eligible coin wins.
  always_comb begin
    pick = 5'b00000;
    for (int i = 0; i < 5; i++) begin
      if (eligible[i]) pick = 5'b00001 << i;
    end
  end

  always_comb begin
    coin_val = 8'd0;
    for (int i = 0; i < 5; i++) begin
      if (coin_reg[i]) coin_val = denom_val(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (start) state_next = SELECT;
      SELECT:   state_next = (pick != 5'b00000) ? DRIVE : DONE;
      DRIVE:    if (pulse_last) state_next = WAIT_ACK;
      WAIT_ACK: begin
        if (coin_ack)     state_next = SELECT;
        else if (timeout) state_next = FAULT;
      end
      DONE:     state_next = IDLE;
      FAULT:    state_next = FAULT;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    coin     = 5'b00000;
    coin_out = 1'b0;
    busy     = (state_reg != IDLE);
    done     = (state_reg == DONE);
    fault    = (state_reg == FAULT);
    if (state_reg == DRIVE || state_reg == WAIT_ACK) coin = coin_reg;
    if (state_reg == DRIVE) coin_out = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining_reg <= 8'd0;
      coin_reg      <= 5'b00000;
      short_reg     <= 1'b0;
      pulse_cnt_reg <= '0;
      wait_cnt_reg  <= 8'd0;
    end else begin
      if (start_take) begin
        remaining_reg <= amount;
        short_reg     <= 1'b0;
      end else if (ack_take) begin
        remaining_reg <= remaining_reg - coin_val;
      end
      if (state_reg == SELECT) begin
        coin_reg <= pick;
        if (pick == 5'b00000 && remaining_reg != 8'd0) short_reg <= 1'b1;
      end
      pulse_cnt_reg <= (state_reg == DRIVE && state_next == DRIVE) ? pulse_cnt_reg + PW'(1) : '0;
      wait_cnt_reg  <= (state_reg == WAIT_ACK && state_next == WAIT_ACK) ? wait_cnt_reg + 8'd1 : 8'd0;
    end
  end

  assign short     = short_reg;
  assign remaining = remaining_reg;
  assign five      = count_all[0];
  assign ten       = count_all[1];
  assign twenty    = count_all[2];
  assign fifty     = count_all[3];
  assign hundred   = count_all[4];

endmodule

// File: tb/tb_coin_dispenser.sv
// Bench for coin_dispenser: fixed vectors, hand-built corner sequences and
// random refunds checked against a greedy change-making model of the hoppers.
module tb_coin_dispenser;
  localparam int PULSE = 4;
  localparam int TMO   = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] amount = 8'd0;
  logic       load_hopper = 1'b0;
  logic [4:0] load_denom = 5'd0;
  logic [3:0] load_count = 4'd0;
  logic       coin_ack = 1'b0;
  logic [4:0] coin;
  logic       coin_out, busy, done, short, fault;
  logic [7:0] remaining;
  logic [3:0] five, ten, twenty, fifty, hundred;

  coin_dispenser #(.HOPPER_INIT(4'd15), .PULSE_CYCLES(PULSE), .ACK_TIMEOUT(8'(TMO))) dut (
    .clk(clk), .reset(reset), .start(start), .amount(amount),
    .load_hopper(load_hopper), .load_denom(load_denom), .load_count(load_count),
    .coin_ack(coin_ack), .coin(coin), .coin_out(coin_out), .busy(busy), .done(done),
    .short(short), .fault(fault), .remaining(remaining),
    .five(five), .ten(ten), .twenty(twenty), .fifty(fifty), .hundred(hundred)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst_first;
    bit         do_load;
    logic [4:0] ld_denom;
    logic [3:0] ld_cnt;
    int         amt;
    int         e_short;
    int         e_rem;
    int         e_cnt[5];
  } vec_t;

  int    errors = 0;
  int    checks = 0;
  int    vals[5] = '{5, 10, 20, 50, 100};
  string cname[5] = '{"five", "ten", "twenty", "fifty", "hundred"};
  int    hop[5];
  int    exp_q[$];
  int    got[$];
  int    m_rem, m_short;
  int    m_cnt[5];
  int    r_rem, r_short;
  int    r_cnt[5];
  bit    seen_done;
  vec_t  vecs[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) hop[i] = 15;
  endtask

  // Greedy change-making over the modelled inventory.
  task automatic model_txn(input int amt);
    exp_q.delete();
    m_rem = amt;
    for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    while (1) begin
      int p;
      p = -1;
      for (int i = 4; i >= 0; i--)
        if (p < 0 && vals[i] <= m_rem && hop[i] > 0) p = i;
      if (p < 0) break;
      exp_q.push_back(1 << p);
      m_rem -= vals[p];
      hop[p]--;
      if (m_cnt[p] < 15) m_cnt[p]++;
    end
    m_short = (m_rem != 0) ? 1 : 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  task automatic do_load(input logic [4:0] d, input logic [3:0] c);
    load_hopper = 1'b1; load_denom = d; load_count = c;
    @(negedge clk);
    load_hopper = 1'b0;
    for (int i = 0; i < 5; i++) if (d == 5'(1 << i)) hop[i] = c;
    $display("load denom=%b count=%0d", d, c);
  endtask

  task automatic sample_counts();
    r_cnt[0] = five; r_cnt[1] = ten; r_cnt[2] = twenty; r_cnt[3] = fifty; r_cnt[4] = hundred;
  endtask

  // Drives one refund, acting as the hopper mechanism; inj_cyc >= 0 pulses a stray start.
  task automatic run_txn(input int amt, input int max_delay, input int inj_cyc);
    int pulse_len, wait_left;
    got.delete();
    seen_done = 0;
    start = 1'b1; amount = 8'(amt);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    pulse_len = 0; wait_left = 0;
    for (int cyc = 0; cyc < 1000 && !seen_done; cyc++) begin
      coin_ack = 1'b0;
      start = (cyc == inj_cyc);
      if (cyc == inj_cyc) amount = 8'd50;
      if (done) begin
        seen_done = 1;
        r_short = short; r_rem = remaining;
        sample_counts();
      end else if (coin_out) begin
        pulse_len++;
        if (pulse_len == 1) got.push_back(coin);
        coin_ack = ($urandom_range(0, 3) == 0);
      end else if (coin != 5'd0) begin
        if (pulse_len != 0) begin
          chk("pulse_len", pulse_len, PULSE);
          if (got.size() > 0) chk("coin_held", coin, got[got.size()-1]);
          pulse_len = 0;
          wait_left = $urandom_range(0, max_delay);
        end
        if (wait_left == 0) coin_ack = 1'b1;
        else wait_left--;
      end
      if (!seen_done) @(negedge clk);
    end
    start = 1'b0; coin_ack = 1'b0;
    chk("done_seen", seen_done, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  task automatic run_and_check(input int amt, input int max_delay, input int inj_cyc);
    model_txn(amt);
    run_txn(amt, max_delay, inj_cyc);
    chk("coin_total", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk("coin_seq", got[i], exp_q[i]);
    chk("remaining", r_rem, m_rem);
    chk("short", r_short, m_short);
    for (int i = 0; i < 5; i++) chk(cname[i], r_cnt[i], m_cnt[i]);
    $display("txn amount=%0d coins=%0d short=%0d remaining=%0d counts=%0d/%0d/%0d/%0d/%0d",
             amt, got.size(), r_short, r_rem, r_cnt[4], r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]);
  endtask

  initial begin
    int waits;
    vecs[0] = '{1'b1, 1'b0, 5'b00000, 4'd0, 185, 0, 0, '{1, 1, 1, 1, 1}};
    vecs[1] = '{1'b1, 1'b1, 5'b00100, 4'd0,  40, 0, 0, '{0, 4, 0, 0, 0}};
    vecs[2] = '{1'b0, 1'b0, 5'b00000, 4'd0,   7, 1, 2, '{1, 0, 0, 0, 0}};
    vecs[3] = '{1'b0, 1'b0, 5'b00000, 4'd0,   0, 0, 0, '{0, 0, 0, 0, 0}};

    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_coin", coin, 0);       chk("rst_coin_out", coin_out, 0);
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_short", short, 0);     chk("rst_fault", fault, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_counts", {hundred, fifty, twenty, ten, five}, 0);

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].rst_first) do_reset();
      if (vecs[v].do_load) do_load(vecs[v].ld_denom, vecs[v].ld_cnt);
      run_and_check(vecs[v].amt, 0, -1);
      chk("vec_short", r_short, vecs[v].e_short);
      chk("vec_remaining", r_rem, vecs[v].e_rem);
      for (int i = 0; i < 5; i++) chk({"vec_", cname[i]}, r_cnt[i], vecs[v].e_cnt[i]);
    end

    // Ten hopper should be down to 11: drain it with larger coins unavailable.
    do_load(5'b10000, 4'd0);
    do_load(5'b01000, 4'd0);
    run_and_check(120, 1, -1);
    chk("ten_hopper_left", r_cnt[1], 11);
    chk("five_after_tens", r_cnt[0], 2);

    // Stray start while busy must not be queued.
    do_reset();
    run_and_check(30, 2, 3);
    chk("busy_start_coins", got.size(), 2);
    chk("busy_start_fifty", r_cnt[3], 0);

    // Start and load together: start wins, amount 0 finishes two cycles later.
    start = 1'b1; amount = 8'd0;
    load_hopper = 1'b1; load_denom = 5'b00100; load_count = 4'd0;
    @(negedge clk);
    start = 1'b0; load_hopper = 1'b0;
    chk("zero_done_early", done, 0);
    chk("zero_coin_out1", coin_out, 0);
    @(negedge clk);
    chk("zero_done_latency", done, 1);
    chk("zero_short", short, 0);
    chk("zero_coin_out2", coin_out, 0);
    @(negedge clk);
    run_and_check(20, 0, -1);
    chk("load_dropped_twenty", r_cnt[2], 1);

    // First coin latency, then reset in the middle of DRIVE.
    start = 1'b1; amount = 8'd5;
    @(negedge clk);
    start = 1'b0;
    chk("lat_select_coin_out", coin_out, 0);
    @(negedge clk);
    chk("lat_drive_coin_out", coin_out, 1);
    chk("lat_drive_coin", coin, 5'b00001);
    chk("lat_remaining", remaining, 5);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_coin_out", coin_out, 0);
    chk("mid_rst_coin", coin, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_remaining", remaining, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("post_rst_coin_out", coin_out, 0);
    $display("txn reset during drive checked");

    // Ack withheld on the first coin until the jam timeout fires.
    start = 1'b1; amount = 8'd100;
    @(negedge clk);
    start = 1'b0;
    waits = 0;
    for (int g = 0; g < 600 && !fault; g++) begin
      if (coin != 5'd0 && !coin_out) waits++;
      @(negedge clk);
    end
    chk("tmo_fault", fault, 1);
    chk("tmo_wait_cycles", waits, TMO);
    chk("tmo_busy", busy, 1);
    chk("tmo_coin", coin, 0);
    chk("tmo_remaining", remaining, 100);
    chk("tmo_hundred", hundred, 0);
    start = 1'b1; amount = 8'd5;
    load_hopper = 1'b1; load_denom = 5'b00001; load_count = 4'd0;
    @(negedge clk);
    start = 1'b0; load_hopper = 1'b0;
    repeat (8) @(negedge clk);
    chk("fault_sticky", fault, 1);
    chk("fault_no_coin_out", coin_out, 0);
    chk("fault_no_done", done, 0);
    chk("fault_remaining", remaining, 100);
    do_reset();
    chk("fault_cleared", fault, 0);
    chk("fault_rst_busy", busy, 0);
    $display("txn ack timeout waits=%0d", waits);
    run_and_check(185, 0, -1);

    // Random refunds and refills against the model.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [4:0] d;
        d = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'(1 << $urandom_range(0, 4));
        do_load(d, 4'($urandom_range(0, 15)));
      end else begin
        run_and_check($urandom_range(0, 255), 3, -1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
